// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   rx_state_t    : receive deframer state encoding
//   RXERR_*       : bit positions inside the 3-bit Rx_Error status word
//   even_parity() : even-parity bit for a data word, shared with the transmitter
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_DONE,
      S_BRK_WAIT
   } rx_state_t;

   localparam int RXERR_BREAK  = 0;
   localparam int RXERR_PARITY = 1;
   localparam int RXERR_FRAME  = 2;

   // Narrower words are zero-extended by the caller; zeros do not change the XOR.
   function automatic logic even_parity(input logic [31:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
//   SysClk : clock
//   Rst    : synchronous active-high reset, loads RST_VAL into both flops
//   D      : asynchronous input
//   Q      : synchronized output
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic SysClk,
   input  logic Rst,
   input  logic D,
   output logic Q
);

   logic meta;

   always_ff @(posedge SysClk) begin
      if (Rst) begin
         meta <= RST_VAL;
         Q    <= RST_VAL;
      end else begin
         meta <= D;
         Q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start bit, DATA_BITS data bits MSB first, optional
// even-parity bit, STOP_BITS stop bits. Presents each word with error flags.
//   SysClk   : clock
//   Rst      : synchronous active-high reset
//   Rx       : asynchronous serial line, idle high
//   Data_Out : last received word (0 after a break)
//   Data_Rdy : one-cycle strobe per completed frame
//   Rx_Error : [0] break, [1] parity, [2] frame
//   Rx_Busy  : high while a frame (or a break) is in progress
//
// state      | meaning
// -----------+-------------------------------------------------
// S_IDLE     | line idle, waiting for a falling edge
// S_START    | half-bit wait, then confirm start bit is still low
// S_DATA     | sampling data bits at mid-bit
// S_PARITY   | sampling the parity bit
// S_STOP     | sampling stop bits
// S_DONE     | one cycle: publish word and flags
// S_BRK_WAIT | break received, waiting for the line to go high
module uart_rx_deframer
   import uart_pkg::*;
#(
   parameter int SYSCLK_RATE = 100000000,
   parameter int BAUD_RATE   = 9600,
   parameter int DATA_BITS   = 8,
   parameter int PARITY_BIT  = 1,
   parameter int STOP_BITS   = 2
) (
   input  logic                 SysClk,
   input  logic                 Rst,
   input  logic                 Rx,
   output logic [DATA_BITS-1:0] Data_Out,
   output logic                 Data_Rdy,
   output logic [2:0]           Rx_Error,
   output logic                 Rx_Busy
);

   localparam int CLKS_PER_BIT = SYSCLK_RATE / BAUD_RATE;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int BIT_W        = $clog2(DATA_BITS + 1);

   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

   logic rx_s;
   logic rx_s_d;

   rx_state_t            state,   state_nxt;
   logic [CNT_W-1:0]     cnt,     cnt_nxt;
   logic [BIT_W-1:0]     bit_cnt, bit_nxt;
   logic [DATA_BITS-1:0] shift,   shift_nxt;
   logic                 par_err, par_nxt;
   logic                 frm_err, frm_nxt;
   logic                 any_one, one_nxt;
   logic [DATA_BITS-1:0] dout_nxt;
   logic [2:0]           err_nxt;
   logic                 rdy_nxt;
   logic                 busy_nxt;
   logic                 tick;
   logic                 fall;
   logic [31:0]          pword;

   uart_sync2 #(.RST_VAL(1'b1)) u_sync (
      .SysClk (SysClk),
      .Rst    (Rst),
      .D      (Rx),
      .Q      (rx_s)
   );

   always_ff @(posedge SysClk) begin
      if (Rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         par_err  <= 1'b0;
         frm_err  <= 1'b0;
         any_one  <= 1'b0;
         rx_s_d   <= 1'b1;
         Data_Out <= '0;
         Rx_Error <= '0;
         Data_Rdy <= 1'b0;
         Rx_Busy  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         bit_cnt  <= bit_nxt;
         shift    <= shift_nxt;
         par_err  <= par_nxt;
         frm_err  <= frm_nxt;
         any_one  <= one_nxt;
         rx_s_d   <= rx_s;
         Data_Out <= dout_nxt;
         Rx_Error <= err_nxt;
         Data_Rdy <= rdy_nxt;
         Rx_Busy  <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bit_nxt   = bit_cnt;
      shift_nxt = shift;
      par_nxt   = par_err;
      frm_nxt   = frm_err;
      one_nxt   = any_one;
      dout_nxt  = Data_Out;
      err_nxt   = Rx_Error;
      rdy_nxt   = 1'b0;
      busy_nxt  = (state != S_IDLE);
      tick      = (cnt == '0);
      fall      = rx_s_d & ~rx_s;
      pword     = '0;
      pword[DATA_BITS-1:0] = shift;

      case (state)
         S_IDLE: begin
            if (fall) begin
               state_nxt = S_START;
               cnt_nxt   = HALF_LOAD;
            end
         end
         S_START: begin
            if (!tick) begin
               cnt_nxt = cnt - 1'b1;
            end else if (rx_s) begin
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_DATA;
               cnt_nxt   = FULL_LOAD;
               bit_nxt   = '0;
               par_nxt   = 1'b0;
               frm_nxt   = 1'b0;
               one_nxt   = 1'b0;
            end
         end
         S_DATA: begin
            if (!tick) begin
               cnt_nxt = cnt - 1'b1;
            end else begin
               cnt_nxt   = FULL_LOAD;
               shift_nxt = {shift[DATA_BITS-2:0], rx_s};
               one_nxt   = any_one | rx_s;
               if (bit_cnt == LAST_DATA) begin
                  bit_nxt   = '0;
                  state_nxt = (PARITY_BIT != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_nxt = bit_cnt + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (!tick) begin
               cnt_nxt = cnt - 1'b1;
            end else begin
               cnt_nxt   = FULL_LOAD;
               par_nxt   = (rx_s != even_parity(pword));
               one_nxt   = any_one | rx_s;
               bit_nxt   = '0;
               state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (!tick) begin
               cnt_nxt = cnt - 1'b1;
            end else begin
               cnt_nxt = FULL_LOAD;
               one_nxt = any_one | rx_s;
               if (!rx_s) frm_nxt = 1'b1;
               if (bit_cnt == LAST_STOP) begin
                  state_nxt = S_DONE;
               end else begin
                  bit_nxt = bit_cnt + 1'b1;
               end
            end
         end
         S_DONE: begin
            rdy_nxt = 1'b1;
            err_nxt = '0;
            if (any_one) begin
               dout_nxt              = shift;
               err_nxt[RXERR_PARITY] = par_err;
               err_nxt[RXERR_FRAME]  = frm_err;
            end else begin
               dout_nxt             = '0;
               err_nxt[RXERR_BREAK] = 1'b1;
            end
            // Edge detector stays armed here so a tight back-to-back start is caught.
            if (fall) begin
               state_nxt = S_START;
               cnt_nxt   = HALF_LOAD;
            end else if (!rx_s && !any_one) begin
               state_nxt = S_BRK_WAIT;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_BRK_WAIT: begin
            if (rx_s) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Serial receive front end of the UART. Samples the `Rx` line on `SysClk`, recovers each frame (start bit, data MSB first, optional even-parity bit, `STOP_BITS` stop bits) and presents the data word with per-frame error flags. Downstream, the receive FIFO pushes on `Data_Rdy`; `Data_Out` and `Rx_Error` feed the FIFO write port and the host-visible error status.

## Interface
- `SYSCLK_RATE`, 100000000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line bit rate in Hz. `CLKS_PER_BIT = SYSCLK_RATE/BAUD_RATE` is an integer division and must be ≥ 4.
- `DATA_BITS`, 8: data bits per frame.
- `PARITY_BIT`, 1: 1 = even-parity bit present, 0 = no parity bit.
- `STOP_BITS`, 2: stop bits per frame, 1 or 2.

Ports:
- `SysClk` in 1: the single clock. All logic is on the rising edge.
- `Rst` in 1: synchronous, active-high reset.
- `Rx` in 1: asynchronous serial line, idle high.
- `Data_Out` out DATA_BITS: last received word.
- `Data_Rdy` out 1: one-cycle strobe; frame complete.
- `Rx_Error` out 3: [0] break, [1] parity, [2] frame.
- `Rx_Busy` out 1: high from start-edge detection until the frame is done.

## Operation
- `Rx` passes through a 2-flop synchronizer. The result is `rx_s`, which resets to 1. All logic uses `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE, BRK_WAIT.
- **IDLE:** on `rx_s` falling (1 then 0), go to START and load the bit counter with `CLKS_PER_BIT/2 - 1`.
- **START:** when the counter reaches 0, sample `rx_s`.
  - 1: false start; return to IDLE with no strobe.
  - 0: go to DATA.
- **DATA:** sample once every `CLKS_PER_BIT` cycles, at mid-bit.
  - The first sample goes to bit `DATA_BITS-1`, the last to bit 0.
  - After `DATA_BITS` samples, go to PARITY if `PARITY_BIT` is 1, else to STOP.
- **PARITY:** one sample. The parity error is set when the sample differs from the XOR of the received data bits.
- **STOP:** `STOP_BITS` samples. The frame error is set if any stop sample is 0.
- **DONE:** one cycle.
  - Drive `Data_Out` with the shift register, `Rx_Error` with the computed flags, and `Data_Rdy` = 1.
  - Next state is IDLE if `rx_s` is 1. Otherwise, for a break, next state is BRK_WAIT.
- **Break:** all data, parity and stop samples are 0.
  - `Rx_Error` = 3'b001; the parity and frame flags are suppressed.
  - `Data_Out` = 0.
  - `Data_Rdy` still pulses.
- **BRK_WAIT:** `Rx_Busy` stays high until `rx_s` is 1, then go to IDLE. A low line never produces a second frame.
- A non-break frame that ends with the line low goes to IDLE. No new start edge is seen until `rx_s` rises and falls again.
- `Data_Out` and `Rx_Error` hold their values until the next DONE.
- `Rx_Busy` is low only in IDLE.
- **Reset** at any time, including mid-frame, sets:
  - state = IDLE, counters = 0, `rx_s` = 1
  - `Data_Out` = 0, `Rx_Error` = 0, `Data_Rdy` = 0, `Rx_Busy` = 0

## Timing
- Bit sample points are at `T0 + 2 + CLKS_PER_BIT/2 + k*CLKS_PER_BIT` for k = 0 to `TX_BITS-1`, where:
  - `T0` is the cycle `Rx` is first sampled low.
  - `TX_BITS = 1 + DATA_BITS + PARITY_BIT + STOP_BITS`.
- `Data_Rdy` asserts 1 cycle after the last stop sample.
- `Rx_Busy` rises 3 cycles after `T0` and falls on the cycle after DONE (not BRK_WAIT).
- **Back-to-back frames:** the next start edge can arrive as early as half a bit after the last stop sample. The 1-cycle DONE must not miss it; the edge detector stays armed in DONE.
- **Counter:** `$clog2(CLKS_PER_BIT)` bits, reloaded with `CLKS_PER_BIT-1` at each sample.

## Structure
- `uart_pkg` holds:
  - the state enum `rx_state_t`
  - the error-index constants `RXERR_BREAK=0`, `RXERR_PARITY=1`, `RXERR_FRAME=2`
  - the function `even_parity()`, shared with the transmitter
- One sub-module: `uart_sync2`, the 2-flop synchronizer with a reset value parameter.

## Test plan
Bench parameters: `SYSCLK_RATE=1600`, `BAUD_RATE=100`, giving `CLKS_PER_BIT=16`; `DATA_BITS=8`, `PARITY_BIT=1`, `STOP_BITS=2`.

- **Good frame:** frame 8'hA5 with correct parity -> one `Data_Rdy`, `Data_Out`=8'hA5, `Rx_Error`=3'b000, strobe at `T0+2+8+11*16+1`.
- **Parity error:** 8'hAA with the parity bit inverted -> `Data_Out`=8'hAA, `Rx_Error`=3'b010.
- **Frame error:** 8'hAA with both stop bits 0, line then returned high -> `Rx_Error`=3'b100, `Data_Rdy` once.
- **Break:** line held low for 30 bit times -> exactly one `Data_Rdy`, `Data_Out`=0, `Rx_Error`=3'b001, `Rx_Busy` high until the line returns high.
- **False start:** a 5-cycle low glitch -> no `Data_Rdy`, `Rx_Busy` back to 0 within 10 cycles.
- **Back-to-back and reset:** frames 8'h01 then 8'hFE with zero idle gap -> two strobes with the correct data. `Rst` asserted mid-way through a third frame -> all outputs 0 next cycle, and a subsequent 8'h3C is received cleanly.
